btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer for the pipelined RV32IM core. It replaces the direct-mapped single-entry-per-index BTB.
- IF stage does a same-cycle lookup on the fetch PC.
- EX stage writes back resolved branch/jump outcomes.
- New over the predecessor: configurable sets/ways, per-entry saturating direction counters, per-set round-robin replacement and a bulk invalidate (used by fence.i / context change).

---
 rtl/btb_pkg.sv | 33 +++
 rtl/btb_assoc_if.sv | 26 ++
 rtl/btb_sat_counter.sv | 22 ++
 rtl/btb_assoc.sv | 107 ++++++++++
 tb/tb_btb_assoc.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared constants, address helpers and entry layout for the
// set-associative branch target buffer.
package btb_pkg;

    localparam int unsigned AW_MAX = 64;

    localparam logic [1:0] CNT_ALLOC_DEF = 2'b10;
    localparam logic [1:0] CNT_MAX_DEF   = 2'b11;
    localparam logic [1:0] CNT_MIN_DEF   = 2'b00;

    typedef logic [AW_MAX-1:0] addr_t;

    function automatic addr_t cnt_max(input int unsigned w);
        return (addr_t'(1) << w) - addr_t'(1);
    endfunction

    function automatic addr_t idx_of(input addr_t pc, input int unsigned sets);
        return (pc >> 2) & (addr_t'(sets) - addr_t'(1));
    endfunction

    function automatic addr_t tag_of(input addr_t pc, input int unsigned sets);
        return pc >> (2 + $clog2(sets));
    endfunction

    // Entry layout for the default 32-bit, 16-set configuration.
    typedef struct packed {
        logic        valid;
        logic [25:0] tag;
        logic [31:0] target;
        logic [1:0]  cnt;
    } btb_entry_t;

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and execute-side update bundle of the BTB.
interface btb_assoc_if #(parameter int XLEN = 32);

    logic [XLEN-1:0] pc;
    logic            valid;
    logic            predicted_taken;
    logic [XLEN-1:0] target_pc;
    logic            update;
    logic [XLEN-1:0] update_pc;
    logic            update_taken;
    logic [XLEN-1:0] update_target;
    logic            flush_all;

    modport master (
        output pc, update, update_pc, update_taken,
        output update_target, flush_all,
        input  valid, predicted_taken, target_pc
    );

    modport slave (
        input  pc, update, update_pc, update_taken,
        input  update_target, flush_all,
        output valid, predicted_taken, target_pc
    );

endinterface

// File: rtl/btb_sat_counter.sv
// Saturating up/down direction counter next-value logic.
module btb_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] i_cnt,
    input  logic         i_taken,
    output logic [W-1:0] o_cnt_next
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] MIN = '0;

    always_comb begin
        o_cnt_next = i_cnt;
        unique case (1'b1)
            i_taken && (i_cnt != MAX):  o_cnt_next = i_cnt + 1'b1;
            !i_taken && (i_cnt != MIN): o_cnt_next = i_cnt - 1'b1;
            default:                    o_cnt_next = i_cnt;
        endcase
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: same-cycle lookup for IF, registered update
// from EX with round-robin replacement and bulk invalidate.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              SETS      = 16,
    parameter int              WAYS      = 2,
    parameter int              CNT_BITS  = 2,
    parameter logic [CNT_BITS-1:0] CNT_ALLOC = CNT_BITS'(CNT_ALLOC_DEF)
) (
    input  logic           clk,
    input  logic           rst,
    btb_assoc_if.slave     bus
);

    localparam int IB = $clog2(SETS);
    localparam int TW = XLEN - 2 - IB;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                r_vld [SETS][WAYS];
    logic [TW-1:0]       r_tag [SETS][WAYS];
    logic [XLEN-1:0]     r_tgt [SETS][WAYS];
    logic [CNT_BITS-1:0] r_cnt [SETS][WAYS];
    logic [WB-1:0]       r_ptr [SETS];

    logic [IB-1:0]       w_lidx, w_uidx;
    logic [TW-1:0]       w_ltag, w_utag;
    logic                w_lhit, w_uhit, w_uinv;
    logic [WB-1:0]       w_lway, w_uway, w_iway, w_vway;
    logic [CNT_BITS-1:0] w_cnt_next;

    assign w_lidx = IB'(idx_of(AW_MAX'(bus.pc), SETS));
    assign w_ltag = TW'(tag_of(AW_MAX'(bus.pc), SETS));
    assign w_uidx = IB'(idx_of(AW_MAX'(bus.update_pc), SETS));
    assign w_utag = TW'(tag_of(AW_MAX'(bus.update_pc), SETS));

    // Descending scans leave the lowest matching way selected.
    always_comb begin
        w_lhit = 1'b0;
        w_lway = '0;
        w_uhit = 1'b0;
        w_uway = '0;
        w_uinv = 1'b0;
        w_iway = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_vld[w_lidx][w] && r_tag[w_lidx][w] == w_ltag) begin
                w_lhit = 1'b1;
                w_lway = WB'(w);
            end
            if (r_vld[w_uidx][w] && r_tag[w_uidx][w] == w_utag) begin
                w_uhit = 1'b1;
                w_uway = WB'(w);
            end
            if (!r_vld[w_uidx][w]) begin
                w_uinv = 1'b1;
                w_iway = WB'(w);
            end
        end
    end

    assign w_vway = w_uinv ? w_iway : r_ptr[w_uidx];

    assign bus.valid = rst && w_lhit;
    assign bus.predicted_taken =
        rst && w_lhit && r_cnt[w_lidx][w_lway][CNT_BITS-1];
    assign bus.target_pc =
        (rst && w_lhit) ? r_tgt[w_lidx][w_lway] : '0;

    btb_sat_counter #(.W(CNT_BITS)) u_cnt (
        .i_cnt      (r_cnt[w_uidx][w_uway]),
        .i_taken    (bus.update_taken),
        .o_cnt_next (w_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_vld[s][w] <= 1'b0;
                    r_tag[s][w] <= '0;
                    r_tgt[s][w] <= '0;
                    r_cnt[s][w] <= CNT_ALLOC;
                end
            end
        end else if (bus.flush_all) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_vld[s][w] <= 1'b0;
        end else if (bus.update) begin
            if (w_uhit) begin
                r_cnt[w_uidx][w_uway] <= w_cnt_next;
                if (bus.update_taken)
                    r_tgt[w_uidx][w_uway] <= bus.update_target;
            end else if (bus.update_taken) begin
                r_vld[w_uidx][w_vway] <= 1'b1;
                r_tag[w_uidx][w_vway] <= w_utag;
                r_tgt[w_uidx][w_vway] <= bus.update_target;
                r_cnt[w_uidx][w_vway] <= CNT_ALLOC;
                if (!w_uinv && WAYS > 1)
                    r_ptr[w_uidx] <= r_ptr[w_uidx] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed scoreboard bench for btb_assoc at default parameters.
module tb_btb_assoc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btb_assoc_if #(.XLEN(32)) bus ();

    btb_assoc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic        p;
        logic [31:0] t;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic up,
                       input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic fl,
                       input logic [31:0] lpc, input logic ev,
                       input logic ep, input logic [31:0] et,
                       input string tag);
        exp_t e;
        exp_t g;
        rst               = r;
        bus.update        = up;
        bus.update_pc     = upc;
        bus.update_taken  = ut;
        bus.update_target = utg;
        bus.flush_all     = fl;
        bus.pc            = lpc;
        e.v = ev;
        e.p = ep;
        e.t = et;
        e.tag = tag;
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        chk({g.tag, ".valid"}, 32'(bus.valid), 32'(g.v));
        chk({g.tag, ".taken"}, 32'(bus.predicted_taken), 32'(g.p));
        chk({g.tag, ".target"}, bus.target_pc, g.t);
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] lpc, input logic ev,
                        input logic ep, input logic [31:0] et,
                        input string tag);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lpc, ev, ep, et, tag);
    endtask

    task automatic upd(input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic [31:0] lpc,
                       input logic ev, input logic ep,
                       input logic [31:0] et, input string tag);
        cyc(1'b1, 1'b1, upc, ut, utg, 1'b0, lpc, ev, ep, et, tag);
    endtask

    initial begin
        rst = 1'b0;
        bus.pc = '0;
        bus.update = 1'b0;
        bus.update_pc = '0;
        bus.update_taken = 1'b0;
        bus.update_target = '0;
        bus.flush_all = 1'b0;
        @(posedge clk);
        #1;

        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h40, 0, 0, 0, "rst_out");
        look(32'h40, 0, 0, 32'h0, "cold_miss");

        // Allocation and counter saturation on one entry
        upd(32'h40, 1, 32'h100, 32'h40, 0, 0, 32'h0, "alloc_same");
        upd(32'h40, 0, 32'hDEAD, 32'h40, 1, 1, 32'h100, "hit_c10");
        upd(32'h40, 0, 32'hDEAD, 32'h40, 1, 0, 32'h100, "nt_c01");
        upd(32'h40, 0, 32'hDEAD, 32'h40, 1, 0, 32'h100, "nt_c00");
        upd(32'h40, 1, 32'h200, 32'h40, 1, 0, 32'h100, "sat_low");
        upd(32'h40, 1, 32'h200, 32'h40, 1, 0, 32'h200, "t_c01");
        upd(32'h40, 1, 32'h200, 32'h40, 1, 1, 32'h200, "t_c10");
        upd(32'h40, 1, 32'h200, 32'h40, 1, 1, 32'h200, "t_c11");
        upd(32'h40, 0, 32'hDEAD, 32'h40, 1, 1, 32'h200, "sat_high");
        look(32'h40, 1, 1, 32'h200, "after_sat");

        // Reset forces outputs low even while an entry is valid
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h40, 0, 0, 0, "rst_force");
        look(32'h40, 0, 0, 32'h0, "rst_clear");

        // Conflict and round-robin replacement in set 0
        upd(32'h40, 1, 32'h1000, 32'h80, 0, 0, 32'h0, "alloc_w0");
        upd(32'h80, 1, 32'h2000, 32'h40, 1, 1, 32'h1000, "alloc_w1");
        upd(32'hC0, 1, 32'h3000, 32'h80, 1, 1, 32'h2000, "alloc_evict");
        look(32'h40, 0, 0, 32'h0, "evicted");
        look(32'h80, 1, 1, 32'h2000, "keep_80");
        look(32'hC0, 1, 1, 32'h3000, "keep_C0");
        upd(32'h140, 0, 32'hDEAD, 32'h140, 0, 0, 32'h0, "nt_miss");
        look(32'h140, 0, 0, 32'h0, "nt_no_alloc");
        look(32'hC0, 1, 1, 32'h3000, "nt_keep");
        upd(32'h140, 1, 32'h4000, 32'h80, 1, 1, 32'h2000, "rr_way1");
        look(32'h80, 0, 0, 32'h0, "rr_evict");
        look(32'h140, 1, 1, 32'h4000, "rr_new");

        // Same-cycle update not visible until the next cycle
        upd(32'h40, 1, 32'h300, 32'h40, 0, 0, 32'h0, "same_cycle");
        look(32'h40, 1, 1, 32'h300, "same_next");
        look(32'hC0, 0, 0, 32'h0, "rr_wrap");

        // Flush wins over a simultaneous update
        cyc(1'b1, 1'b1, 32'h80, 1, 32'h700, 1'b1, 32'h40,
            1, 1, 32'h300, "flush_cycle");
        look(32'h40, 0, 0, 32'h0, "flush_40");
        look(32'h80, 0, 0, 32'h0, "flush_80");
        look(32'h140, 0, 0, 32'h0, "flush_140");

        // Repopulate then reset mid-operation
        upd(32'h40, 1, 32'h500, 32'h40, 0, 0, 32'h0, "repop_40");
        upd(32'h80, 1, 32'h600, 32'h40, 1, 1, 32'h500, "repop_80");
        look(32'h80, 1, 1, 32'h600, "repop_hit");
        cyc(1'b0, 1'b1, 32'hC0, 1, 32'h900, 1'b0, 32'h80,
            0, 0, 32'h0, "rst_force2");
        look(32'h40, 0, 0, 32'h0, "rst2_40");
        look(32'h80, 0, 0, 32'h0, "rst2_80");
        look(32'hC0, 0, 0, 32'h0, "rst2_C0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
